// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between exe_stage and wb_stage.
// Latches the EXE bus, samples synchronous data-SRAM read data (holding it
// across WB back-pressure), extracts/merges load data and forwards the
// result to WB. Also provides hazard and exception status to DE/EXE.
//
// Optional feature macro: MS_LOAD_FWD_EN
//   defined   - ms_value carries extracted load data, ms_load_block is 0.
//   undefined - ms_value carries the raw value/address, loads raise
//               ms_load_block so decode stalls for one cycle.
//
// Handshake: a transfer EXE->MEM happens on an edge where es_to_ms_valid &
// ms_allowin; MEM->WB happens on an edge where ms_to_ws_valid & ws_allowin.
// A valid producer holds its bus stable until the transfer edge.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 160,
    parameter int MS_TO_WS_BUS_WD = 121
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       eret_flush,
    input  logic                       ws_ex_in,
    output logic                       ms_ex_out,
    output logic [4:0]                 reg_dest_ms,
    output logic [31:0]                ms_value,
    output logic                       ms_load_block,
    output logic                       ms_mfc0,
    output logic                       ms_rd_held_o
);

    typedef enum logic {
        RD_LIVE = 1'b0,
        RD_HELD = 1'b1
    } rd_state_e;

    rd_state_e                  rd_state_q;
    logic                       ms_valid_q;
    logic [31:0]                rdata_hold_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;

    logic        ms_ready_go;
    logic        flush;
    logic [31:0] ld_data;

    // Unpacked fields of the latched EXE bus
    logic [4:0]  f_cp0_rd;
    logic        f_ex;
    logic        f_bd;
    logic [4:0]  f_excode;
    logic [31:0] f_badvaddr;
    logic [2:0]  f_cp0_sel;
    logic        f_eret;
    logic        f_sys;
    logic        f_mtc0;
    logic        f_mfc0;
    logic [31:0] f_rt_value;
    logic        f_lwl;
    logic        f_lwr;
    logic        f_lhu;
    logic        f_lh;
    logic        f_lbu;
    logic        f_lb;
    logic        f_load_op;
    logic        f_gr_we;
    logic [4:0]  f_dest;
    logic [31:0] f_value;
    logic [31:0] f_pc;

    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] lwl_res;
    logic [31:0] lwr_res;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign f_cp0_rd   = bus_q[159:155];
    assign f_ex       = bus_q[154];
    assign f_bd       = bus_q[153];
    assign f_excode   = bus_q[152:148];
    assign f_badvaddr = bus_q[147:116];
    assign f_cp0_sel  = bus_q[115:113];
    assign f_eret     = bus_q[112];
    assign f_sys      = bus_q[111];
    assign f_mtc0     = bus_q[110];
    assign f_mfc0     = bus_q[109];
    assign f_rt_value = bus_q[108:77];
    assign f_lwl      = bus_q[76];
    assign f_lwr      = bus_q[75];
    assign f_lhu      = bus_q[74];
    assign f_lh       = bus_q[73];
    assign f_lbu      = bus_q[72];
    assign f_lb       = bus_q[71];
    assign f_load_op  = bus_q[70];
    assign f_gr_we    = bus_q[69];
    assign f_dest     = bus_q[68:64];
    assign f_value    = bus_q[63:32];
    assign f_pc       = bus_q[31:0];

    assign ms_ready_go    = 1'b1;
    assign flush          = eret_flush | ws_ex_in;
    assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & !flush;

    // Stage valid and read-data hold FSM; flush wins over accept, and a
    // stalled load freezes the SRAM data seen in its first MEM cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            rd_state_q   <= RD_LIVE;
            rdata_hold_q <= 32'd0;
        end else if (flush) begin
            ms_valid_q <= 1'b0;
            rd_state_q <= RD_LIVE;
        end else if (ms_allowin) begin
            ms_valid_q <= es_to_ms_valid;
            rd_state_q <= RD_LIVE;
        end else if (rd_state_q == RD_LIVE && ms_valid_q && f_load_op) begin
            rd_state_q   <= RD_HELD;
            rdata_hold_q <= data_sram_rdata;
        end
    end

    // Bus register loads only on an EXE->MEM transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q <= '0;
        end else if (es_to_ms_valid && ms_allowin && !flush) begin
            bus_q <= es_to_ms_bus;
        end
    end

    assign ld_data      = (rd_state_q == RD_HELD) ? rdata_hold_q : data_sram_rdata;
    assign ms_rd_held_o = (rd_state_q == RD_HELD);
    assign addr_lo      = f_value[1:0];

    // Load extraction and merge with rt for the unaligned lwl/lwr pair
    always_comb begin
        ld_byte = ld_data[7:0];
        lwl_res = ld_data;
        lwr_res = ld_data;
        case (addr_lo)
            2'd0: begin
                ld_byte = ld_data[7:0];
                lwl_res = {ld_data[7:0], f_rt_value[23:0]};
                lwr_res = ld_data;
            end
            2'd1: begin
                ld_byte = ld_data[15:8];
                lwl_res = {ld_data[15:0], f_rt_value[15:0]};
                lwr_res = {f_rt_value[31:24], ld_data[31:8]};
            end
            2'd2: begin
                ld_byte = ld_data[23:16];
                lwl_res = {ld_data[23:0], f_rt_value[7:0]};
                lwr_res = {f_rt_value[31:16], ld_data[31:16]};
            end
            default: begin
                ld_byte = ld_data[31:24];
                lwl_res = ld_data;
                lwr_res = {f_rt_value[31:8], ld_data[31:24]};
            end
        endcase
        ld_half = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

        load_result = ld_data;
        if (f_lwl) begin
            load_result = lwl_res;
        end else if (f_lwr) begin
            load_result = lwr_res;
        end else if (f_lh) begin
            load_result = {{16{ld_half[15]}}, ld_half};
        end else if (f_lhu) begin
            load_result = {16'd0, ld_half};
        end else if (f_lb) begin
            load_result = {{24{ld_byte[7]}}, ld_byte};
        end else if (f_lbu) begin
            load_result = {24'd0, ld_byte};
        end
    end

    assign final_result = f_load_op ? load_result : f_value;

    assign ms_to_ws_bus = {
        f_cp0_rd,            // 120:116
        f_ex,                // 115
        f_bd,                // 114
        f_excode,            // 113:109
        f_badvaddr,          // 108:77
        f_cp0_sel,           // 76:74
        f_eret,              // 73
        f_sys,               // 72
        f_mtc0,              // 71
        f_mfc0,              // 70
        f_gr_we & !f_ex,     // 69: faulting instructions must not write back
        f_dest,              // 68:64
        final_result,        // 63:32
        f_pc                 // 31:0
    };

    assign ms_ex_out   = ms_valid_q & (f_ex | f_eret);
    assign reg_dest_ms = (ms_valid_q & f_gr_we) ? f_dest : 5'd0;
    assign ms_mfc0     = ms_valid_q & f_mfc0;

`ifdef MS_LOAD_FWD_EN
    assign ms_value      = final_result;
    assign ms_load_block = 1'b0;
`else
    // Extractor is kept off the bypass path; decode must stall on loads.
    assign ms_value      = f_value;
    assign ms_load_block = ms_valid_q & f_load_op;
`endif

endmodule
